// File: rtl/pll_ctrl.sv
// pll_ctrl: reset/lock sequencer and dynamic-divider controller for a Gowin rPLL.
// Pulses the PLL reset, waits for a synchronized and stable LOCK, then raises
// `ready`. Divider changes are accepted in RUN through a req/ack handshake.
// A lock timeout triggers a retry. Repeated timeouts latch a sticky fault.
// Build option: define PLL_CTRL_RELOCK_EN to relock after a lock loss in RUN.
// Without it, a lock loss in RUN goes straight to FAULT.
`timescale 1ns/1ps
module pll_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter logic [5:0]  INIT_IDSEL    = 6'd0,
    parameter logic [5:0]  INIT_FBDSEL   = 6'd0,
    parameter logic [5:0]  INIT_ODSEL    = 6'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_cnt
);

    localparam int RC_W = $clog2(RST_CYCLES) + 1;
    localparam int TO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int ST_W = $clog2(STABLE_CYCLES) + 1;

    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(LOCK_TIMEOUT);
    localparam logic [ST_W-1:0] ST_MAX    = ST_W'(STABLE_CYCLES);
    localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            lock_meta_q, lock_meta_d;
    logic            lock_s_q, lock_s_d;
    logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [ST_W-1:0] st_cnt_q, st_cnt_d;
    logic [2:0]      retry_cnt_q, retry_cnt_d;
    logic            pll_reset_q, pll_reset_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;
    logic            cfg_ack_q, cfg_ack_d;
    logic [5:0]      idsel_q, idsel_d;
    logic [5:0]      fbdsel_q, fbdsel_d;
    logic [5:0]      odsel_q, odsel_d;

    logic [TO_W-1:0] to_inc;
    logic [ST_W-1:0] st_inc;
    logic [2:0]      retry_inc;

    // Next-state and next-output logic for the sequencer, counters and lock synchronizer.
    always_comb begin
        state_d     = state_q;
        lock_meta_d = pll_lock;
        lock_s_d    = lock_meta_q;
        rst_cnt_d   = rst_cnt_q;
        to_cnt_d    = to_cnt_q;
        st_cnt_d    = st_cnt_q;
        retry_cnt_d = retry_cnt_q;
        pll_reset_d = pll_reset_q;
        ready_d     = ready_q;
        fault_d     = fault_q;
        cfg_ack_d   = 1'b0;
        idsel_d     = idsel_q;
        fbdsel_d    = fbdsel_q;
        odsel_d     = odsel_q;

        // Saturating increments. The counters hold at their maximum instead of wrapping.
        to_inc    = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
        st_inc    = (st_cnt_q == ST_MAX) ? st_cnt_q : st_cnt_q + 1'b1;
        retry_inc = (retry_cnt_q == 3'd7) ? retry_cnt_q : retry_cnt_q + 3'd1;

        case (state_q)
            ST_RST_PLL: begin
                // A RST_PLL entered from another state spends its first cycle with the reset
                // still low. The pulse length is counted only while pll_reset is high.
                if (pll_reset_q && (rst_cnt_q == RC_LAST)) begin
                    state_d     = ST_WAIT_LOCK;
                    pll_reset_d = 1'b0;
                    rst_cnt_d   = '0;
                    to_cnt_d    = '0;
                    st_cnt_d    = '0;
                end else begin
                    pll_reset_d = 1'b1;
                    rst_cnt_d   = pll_reset_q ? rst_cnt_q + 1'b1 : '0;
                end
            end
            ST_WAIT_LOCK: begin
                to_cnt_d = to_inc;
                if (lock_s_q) begin
                    state_d  = ST_STABLE;
                    st_cnt_d = '0;
                end else if (to_inc == TO_MAX) begin
                    retry_cnt_d = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        state_d     = ST_FAULT;
                        pll_reset_d = 1'b1;
                        fault_d     = 1'b1;
                    end else begin
                        state_d   = ST_RST_PLL;
                        rst_cnt_d = '0;
                    end
                end
            end
            ST_STABLE: begin
                // The timeout keeps running here, so a lock that keeps dropping still times out.
                to_cnt_d = to_inc;
                if (!lock_s_q) begin
                    state_d  = ST_WAIT_LOCK;
                    st_cnt_d = '0;
                end else begin
                    st_cnt_d = st_inc;
                    if (st_inc == ST_MAX) begin
                        state_d     = ST_RUN;
                        ready_d     = 1'b1;
                        retry_cnt_d = '0;
                        st_cnt_d    = '0;
                    end
                end
            end
            ST_RUN: begin
                // A divider request takes priority over a simultaneous lock loss.
                if (cfg_req) begin
                    state_d   = ST_RST_PLL;
                    ready_d   = 1'b0;
                    cfg_ack_d = 1'b1;
                    idsel_d   = cfg_idsel;
                    fbdsel_d  = cfg_fbdsel;
                    odsel_d   = cfg_odsel;
                    rst_cnt_d = '0;
                end else if (!lock_s_q) begin
`ifdef PLL_CTRL_RELOCK_EN
                    state_d   = ST_RST_PLL;
                    ready_d   = 1'b0;
                    rst_cnt_d = '0;
`else
                    state_d     = ST_FAULT;
                    ready_d     = 1'b0;
                    fault_d     = 1'b1;
                    pll_reset_d = 1'b1;
`endif
                end
            end
            ST_FAULT: begin
                pll_reset_d = 1'b1;
                ready_d     = 1'b0;
                fault_d     = 1'b1;
            end
            default: begin
                state_d     = ST_RST_PLL;
                pll_reset_d = 1'b1;
                ready_d     = 1'b0;
                rst_cnt_d   = '0;
            end
        endcase
    end

    // State and output registers. The asynchronous reset restores the INIT_* divider codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RST_PLL;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            st_cnt_q    <= '0;
            retry_cnt_q <= '0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            cfg_ack_q   <= 1'b0;
            idsel_q     <= INIT_IDSEL;
            fbdsel_q    <= INIT_FBDSEL;
            odsel_q     <= INIT_ODSEL;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            st_cnt_q    <= st_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            pll_reset_q <= pll_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            cfg_ack_q   <= cfg_ack_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign cfg_ack    = cfg_ack_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_cnt_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: scoreboard bench for pll_ctrl. The stimulus queues the expected
// output events with hand-computed cycle numbers. A negedge monitor pops and
// compares each event when the DUT shows it.
`timescale 1ns/1ps
module tb_pll_ctrl;

    localparam int EV_SNAP  = 0;
    localparam int EV_ACK   = 1;
    localparam int EV_RFALL = 2;
    localparam int EV_RRISE = 3;
    localparam int EV_PRISE = 4;
    localparam int EV_PFALL = 5;
    localparam int EV_FAULT = 6;

    localparam logic [17:0] C_INIT = {6'h01, 6'h02, 6'h03};
    localparam logic [17:0] C_N    = {6'h05, 6'h0A, 6'h13};
    localparam logic [17:0] C_M    = {6'h21, 6'h22, 6'h23};
    localparam logic [17:0] C_X    = {6'h3F, 6'h3E, 6'h3D};

    typedef struct {
        int          kind;
        int          cyc;
        logic [24:0] snap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
    logic       cfg_ack, ready, fault;
    logic [2:0] retry_cnt;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   snap_cnt = 0, snap_seen = 0;
    int   drain_cnt = 0, drain_seen = 0;
    exp_t exp_q[$];
    logic prev_ready = 1'b0, prev_prst = 1'b1, prev_fault = 1'b0;

    pll_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3),
        .INIT_IDSEL   (6'h01),
        .INIT_FBDSEL  (6'h02),
        .INIT_ODSEL   (6'h03)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .cfg_req   (cfg_req),
        .cfg_idsel (cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel (cfg_odsel),
        .cfg_ack   (cfg_ack),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index: edge k after reset release gives cyc == k.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic logic [24:0] sn(input logic pr, input logic rdy, input logic flt,
                                       input logic ack, input logic [2:0] rc,
                                       input logic [17:0] codes);
        return {pr, rdy, flt, ack, rc, codes};
    endfunction

    function automatic string kname(input int k);
        case (k)
            EV_SNAP:  return "snapshot";
            EV_ACK:   return "cfg_ack";
            EV_RFALL: return "ready_fall";
            EV_RRISE: return "ready_rise";
            EV_PRISE: return "pll_reset_rise";
            EV_PFALL: return "pll_reset_fall";
            EV_FAULT: return "fault_rise";
            default:  return "unknown";
        endcase
    endfunction

    task automatic exp_ev(input int kind, input int c, input logic [24:0] s);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.snap = s;
        exp_q.push_back(e);
    endtask

    task automatic req_snap(input logic [24:0] s);
        exp_ev(EV_SNAP, cyc, s);
        snap_cnt++;
    endtask

    // Monitor side: compare an observed event against the head of the scoreboard.
    task automatic check_ev(input int kind, input logic [24:0] cur);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cyc %0d, required no event", kname(kind), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_order: got %s at cyc %0d, required %s at cyc %0d",
                     kname(kind), cyc, kname(e.kind), e.cyc);
        end
        checks++;
        if (cur !== e.snap) begin
            errors++;
            $display("FAIL %s_outputs at cyc %0d: got rst/rdy/flt/ack=%b%b%b%b retry=%0d sel=%h/%h/%h, required rst/rdy/flt/ack=%b%b%b%b retry=%0d sel=%h/%h/%h",
                     kname(kind), cyc, cur[24], cur[23], cur[22], cur[21], cur[20:18],
                     cur[17:12], cur[11:6], cur[5:0], e.snap[24], e.snap[23], e.snap[22],
                     e.snap[21], e.snap[20:18], e.snap[17:12], e.snap[11:6], e.snap[5:0]);
        end
    endtask

    // Monitor: samples on the falling edge and turns output changes into events.
    always @(negedge clk) begin
        logic [24:0] cur;
        cur = {pll_reset, ready, fault, cfg_ack, retry_cnt, pll_idsel, pll_fbdsel, pll_odsel};
        if (snap_cnt != snap_seen) begin
            snap_seen++;
            check_ev(EV_SNAP, cur);
        end
        if (!rst) begin
            if (cfg_ack)                 check_ev(EV_ACK, cur);
            if (prev_ready && !ready)    check_ev(EV_RFALL, cur);
            if (!prev_ready && ready)    check_ev(EV_RRISE, cur);
            if (!prev_prst && pll_reset) check_ev(EV_PRISE, cur);
            if (prev_prst && !pll_reset) check_ev(EV_PFALL, cur);
            if (!prev_fault && fault)    check_ev(EV_FAULT, cur);
        end
        prev_ready = ready;
        prev_prst  = pll_reset;
        prev_fault = fault;
        if (drain_cnt != drain_seen) begin
            drain_seen++;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL pending_events at cyc %0d: got %0d unseen (first %s at cyc %0d), required 0",
                         cyc, exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
                exp_q.delete();
            end
        end
    end

    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (cyc < n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 5000) begin
                $display("FAIL goto_bound: got cyc %0d, required %0d", cyc, n);
                $fatal(1, "cycle bound expired");
            end
        end
    endtask

    task automatic drain();
        drain_cnt++;
        @(negedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic req, input logic [17:0] codes);
        cfg_req = req;
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = codes;
    endtask

    // Reset the DUT and leave the bench just after edge 0 (cyc == 0).
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pll_lock = 1'b0;
        set_cfg(1'b0, C_X);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        req_snap(sn(1, 0, 0, 0, 3'd0, C_INIT));
    endtask

    initial begin
        // 1. Normal lock: lock 10 cycles after the pll_reset fall at edge 4, ready at 4+21.
        do_reset();
        exp_ev(EV_PFALL, 4,  sn(0, 0, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_RRISE, 25, sn(0, 1, 0, 0, 3'd0, C_INIT));
        goto(14); pll_lock = 1'b1;
        goto(30); drain();

        // 3. One-cycle lock glitch during STABLE forces a full recount; ready at 34.
        do_reset();
        exp_ev(EV_PFALL, 4,  sn(0, 0, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_RRISE, 34, sn(0, 1, 0, 0, 3'd0, C_INIT));
        goto(14); pll_lock = 1'b1;
        goto(22); pll_lock = 1'b0;
        goto(23); pll_lock = 1'b1;
        goto(40); drain();

        // 2. Lock never rises: three reset pulses, then FAULT with retry_cnt = 3.
        do_reset();
        exp_ev(EV_PFALL, 4,   sn(0, 0, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_PRISE, 37,  sn(1, 0, 0, 0, 3'd1, C_INIT));
        exp_ev(EV_PFALL, 41,  sn(0, 0, 0, 0, 3'd1, C_INIT));
        exp_ev(EV_PRISE, 74,  sn(1, 0, 0, 0, 3'd2, C_INIT));
        exp_ev(EV_PFALL, 78,  sn(0, 0, 0, 0, 3'd2, C_INIT));
        exp_ev(EV_PRISE, 110, sn(1, 0, 1, 0, 3'd3, C_INIT));
        exp_ev(EV_FAULT, 110, sn(1, 0, 1, 0, 3'd3, C_INIT));
        goto(130); req_snap(sn(1, 0, 1, 0, 3'd3, C_INIT));
        goto(131); drain();

        // 4. Reconfiguration in RUN, ignored request in WAIT_LOCK, then 6. async reset in STABLE.
        do_reset();
        exp_ev(EV_PFALL, 4,  sn(0, 0, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_RRISE, 25, sn(0, 1, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_ACK,   28, sn(0, 0, 0, 1, 3'd0, C_N));
        exp_ev(EV_RFALL, 28, sn(0, 0, 0, 1, 3'd0, C_N));
        exp_ev(EV_PRISE, 29, sn(1, 0, 0, 0, 3'd0, C_N));
        exp_ev(EV_PFALL, 33, sn(0, 0, 0, 0, 3'd0, C_N));
        exp_ev(EV_RRISE, 54, sn(0, 1, 0, 0, 3'd0, C_N));
        goto(14); pll_lock = 1'b1;
        goto(27); set_cfg(1'b1, C_N);
        goto(28); set_cfg(1'b0, C_X);
        goto(29); pll_lock = 1'b0;
        goto(35); set_cfg(1'b1, C_X);
        goto(40); set_cfg(1'b0, C_X);
        goto(43); pll_lock = 1'b1;
        goto(56);
        exp_ev(EV_ACK,   57, sn(0, 0, 0, 1, 3'd0, C_M));
        exp_ev(EV_RFALL, 57, sn(0, 0, 0, 1, 3'd0, C_M));
        exp_ev(EV_PRISE, 58, sn(1, 0, 0, 0, 3'd0, C_M));
        exp_ev(EV_PFALL, 62, sn(0, 0, 0, 0, 3'd0, C_M));
        set_cfg(1'b1, C_M);
        goto(57); set_cfg(1'b0, C_X);
        goto(66);
        rst = 1'b1;
        req_snap(sn(1, 0, 0, 0, 3'd0, C_INIT));
        @(posedge clk);
        #1;
        req_snap(sn(1, 0, 0, 0, 3'd0, C_INIT));
        drain();

        // 5. Lock loss in RUN: relock when enabled, otherwise straight to FAULT.
        do_reset();
        exp_ev(EV_PFALL, 4,  sn(0, 0, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_RRISE, 25, sn(0, 1, 0, 0, 3'd0, C_INIT));
`ifdef PLL_CTRL_RELOCK_EN
        exp_ev(EV_RFALL, 30, sn(0, 0, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_PRISE, 31, sn(1, 0, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_PFALL, 35, sn(0, 0, 0, 0, 3'd0, C_INIT));
        exp_ev(EV_RRISE, 56, sn(0, 1, 0, 0, 3'd0, C_INIT));
`else
        exp_ev(EV_RFALL, 30, sn(1, 0, 1, 0, 3'd0, C_INIT));
        exp_ev(EV_PRISE, 30, sn(1, 0, 1, 0, 3'd0, C_INIT));
        exp_ev(EV_FAULT, 30, sn(1, 0, 1, 0, 3'd0, C_INIT));
`endif
        goto(14); pll_lock = 1'b1;
        goto(27); pll_lock = 1'b0;
`ifdef PLL_CTRL_RELOCK_EN
        goto(45); pll_lock = 1'b1;
`endif
        goto(70); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_ctrl.md
# pll_ctrl

Reset/lock sequencer and dynamic-divider controller for the Gowin rPLL feeding the WS2812/UART clock domain. Runs on the 27 MHz board reference clock. Pulses the PLL reset, waits for a synchronized and stable LOCK, then releases `ready` to downstream logic. Accepts runtime divider-change requests through a req/ack handshake, retries on lock timeout, and latches a fault after repeated failures.

## Interface
Parameters:
- `RST_CYCLES`, 16: length of the `pll_reset` pulse in clk cycles (≥1).
- `LOCK_TIMEOUT`, 65535: maximum clk cycles to wait for synchronized lock after reset release.
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before `ready` asserts.
- `MAX_RETRIES`, 3: failed lock attempts tolerated before FAULT (1..7).
- `INIT_IDSEL`, `INIT_FBDSEL`, `INIT_ODSEL`, 6'd0: divider codes driven after reset.

Ports:
- `clk`  in  1  27 MHz reference clock (same net as the PLL CLKIN).
- `rst`  in  1  asynchronous, active-high reset.
- `pll_lock`  in  1  rPLL LOCK, asynchronous to `clk`.
- `pll_reset`  out  1  to rPLL RESET.
- `pll_idsel`, `pll_fbdsel`, `pll_odsel`  out  6 each  to rPLL IDSEL/FBDSEL/ODSEL (raw Gowin codes, no translation).
- `cfg_req`  in  1  divider change request.
- `cfg_idsel`, `cfg_fbdsel`, `cfg_odsel`  in  6 each  new codes, valid while `cfg_req`=1.
- `cfg_ack`  out  1  one-cycle pulse when the request is accepted.
- `ready`  out  1  PLL locked and stable; downstream reset release.
- `fault`  out  1  sticky; retries exhausted.
- `retry_cnt`  out  3  failed attempts since the last successful lock.

## Operation
- `pll_lock` is passed through a 2-FF synchronizer (`lock_s`) before any use.
- States:
  - RST_PLL: `pll_reset`=1 for `RST_CYCLES` cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: counter runs. `lock_s`=1 → STABLE. Counter reaches `LOCK_TIMEOUT` → `retry_cnt`+1; if the new value equals `MAX_RETRIES` go to FAULT, else go to RST_PLL.
  - STABLE: counts consecutive `lock_s`=1 cycles. `lock_s`=0 → counter clears and state returns to WAIT_LOCK; the timeout counter continues and is not restarted. Count reaches `STABLE_CYCLES` → RUN, `retry_cnt` clears.
  - RUN: `ready`=1. `cfg_req`=1 → latch the three codes onto `pll_*sel`, pulse `cfg_ack`, go to RST_PLL. `lock_s`=0 → lock-loss handling (see Configuration).
  - FAULT: `pll_reset`=1, `ready`=0, `fault`=1. Exit only via `rst`.
- `cfg_req` outside RUN is ignored, with no ack. The requester holds `cfg_req` until it sees `cfg_ack`. If `cfg_req` and lock loss occur in the same RUN cycle, `cfg_req` wins: the codes are latched and the block goes to RST_PLL.
- `ready` drops in the same cycle RUN is left.
- Counters are sized as clog2(max)+1 and saturate, so they never wrap.

## Timing
- Reset values: `pll_reset`=1, `pll_*sel`=INIT_*, `cfg_ack`=0, `ready`=0, `fault`=0, `retry_cnt`=0, state=RST_PLL.
- All outputs are registered.
- Minimum rst-deassert → `ready` latency: `RST_CYCLES` + 2 (sync) + `STABLE_CYCLES` + 1 cycles.
- `cfg_ack` is high for exactly 1 cycle. The new `pll_*sel` values appear in the same cycle, and `pll_reset` rises in the next cycle.
- Async `rst` mid-sequence forces the reset values immediately. Latched cfg codes are discarded and the outputs revert to INIT_*.

## Configuration
- `PLL_CTRL_RELOCK_EN` defined: lock loss in RUN → RST_PLL, `ready` drops, retries apply.
- Not defined: lock loss in RUN → FAULT directly, with `fault`=1 and `retry_cnt` unchanged.

## Test plan
- Use RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=3 in every scenario.
1. Normal lock: model raises lock 10 cycles after `pll_reset` falls → `ready`=1 at 10+2+8+1 cycles after the fall; `retry_cnt`=0; `fault`=0.
2. Timeout retries: lock never rises → three `pll_reset` pulses, then `fault`=1 and `retry_cnt`=3; `pll_reset` stays high.
3. Glitch in STABLE: lock drops for 1 cycle after 5 stable cycles → `ready` is delayed by a full 8-cycle recount and `retry_cnt` stays 0.
4. Reconfig: in RUN, `cfg_req` with codes 6'h05/6'h0A/6'h13 → one-cycle `cfg_ack`, `pll_*sel` show the new codes, `pll_reset` pulses for 4 cycles, then `ready` returns after relock; `cfg_req` issued in WAIT_LOCK gets no ack.
5. Lock loss in RUN: with `PLL_CTRL_RELOCK_EN` → relock sequence runs and `ready` returns; without it → `fault`=1.
6. Async `rst` asserted in STABLE with latched non-INIT codes → next edge shows all reset values and `pll_*sel`=INIT_*.
